// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall/flush/branch
// handling and an exception drain FSM that vectors to the handler and captures EPC.
module fetch_stage #(
  parameter logic [31:0] PC_RESET        = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR      = 32'h0000_0180,
  parameter int unsigned EXC_WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        if_flush,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  input  logic        exception,
  input  logic [31:0] exc_pc,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] epc,
  output logic        exc_busy
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  localparam logic [XLEN-1:0]  NOP        = '0;
  localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0]  PC_INIT    = PC_RESET & ALIGN_MASK;
  localparam logic [XLEN-1:0]  VEC_ADDR   = EXC_VECTOR & ALIGN_MASK;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(EXC_WAIT_CYCLES - 1);

  typedef enum logic {
    RUN,
    EXC_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  next_pc;

  // Sequential and redirect addresses; the word-offset bits of a branch target are dropped
  assign pc_plus4  = pc + XLEN'(4);
  assign target    = branch_target & ALIGN_MASK;
  assign next_pc   = pc_src ? target : pc_plus4;
  assign imem_addr = pc;

  // PC, IF/ID register and exception drain FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      counter     <= '0;
      pc          <= PC_INIT;
      if_id_instr <= NOP;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      epc         <= '0;
      exc_busy    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (exception) begin
            // Freeze fetch, bubble IF/ID and start draining the pipe
            epc         <= exc_pc;
            if_id_instr <= NOP;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            counter     <= DRAIN_LOAD;
            state       <= EXC_WAIT;
            exc_busy    <= 1'b1;
          end else if (stall) begin
            // Hold everything; a pending branch is re-presented after the stall
            pc <= pc;
          end else if (if_flush) begin
            if_id_instr <= NOP;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b0;
            pc          <= next_pc;
          end else begin
            // Normal fetch; with pc_src alone the fetched word is the delay slot
            if_id_instr <= imem_data;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            pc          <= next_pc;
          end
        end
        EXC_WAIT: begin
          if_id_instr <= NOP;
          if_id_pc4   <= '0;
          if_id_valid <= 1'b0;
          if (counter != '0) begin
            counter <= counter - CNT_W'(1);
          end else begin
            pc       <= VEC_ADDR;
            state    <= RUN;
            exc_busy <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          exc_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of the decode/control unit.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched word into the IF/ID pipeline register.
- Applies stall, branch redirect, IF_Flush and exception redirect, with an FSM that drains the pipe before vectoring to the exception handler and captures EPC.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180, handler address fetched after an exception drain.
- EXC_WAIT_CYCLES, 2, cycles spent in EXC_WAIT before vectoring (legal range 1..15).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall: hold PC and IF/ID.
- if_flush  in  1  IF_Flush from control unit: replace the fetched word with a NOP bubble.
- pc_src  in  1  branch taken: next PC = branch_target.
- branch_target  in  32  branch destination from ID.
- exception  in  1  nonzero exception cause detected downstream (one-cycle pulse).
- exc_pc  in  32  PC of the faulting instruction.
- imem_data  in  32  instruction word; combinational read of imem_addr.
- imem_addr  out  32  current PC.
- if_id_instr  out  32  registered instruction to ID (op = bits 31:26).
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  registered: IF/ID holds a real instruction.
- epc  out  32  captured exception PC.
- exc_busy  out  1  high while the FSM is in EXC_WAIT.

Behaviour:
- Reset (asynchronous, any time, including mid-drain):
  - pc = PC_RESET, if_id_instr = 0 (NOP), if_id_pc4 = 0, if_id_valid = 0, epc = 0.
  - state = RUN, counter = 0, exc_busy = 0.
- imem_addr = pc at all times (combinational from the pc register). pc[1:0] is always 00; branch_target[1:0] is ignored and forced to 00.
- PC arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. if_id_pc4 carries the wrapped value.
- FSM states: RUN, EXC_WAIT.
- RUN, priority top to bottom:
  1. exception=1:
     - epc <= exc_pc.
     - IF/ID <= NOP with valid 0.
     - pc held.
     - counter <= EXC_WAIT_CYCLES-1; state <= EXC_WAIT.
     - Exception overrides stall, pc_src and if_flush in the same cycle.
  2. stall=1:
     - pc and IF/ID held unchanged.
     - pc_src and if_flush are ignored; the hazard unit guarantees the branch is re-evaluated after the stall.
  3. if_flush=1:
     - IF/ID <= NOP, pc4 = pc+4, valid 0.
     - pc <= branch_target if pc_src, else pc+4.
  4. Otherwise:
     - IF/ID <= {imem_data, pc+4, valid 1}.
     - pc <= branch_target if pc_src, else pc+4.
     - pc_src without if_flush means the fetched word is a delay slot and is kept.
- EXC_WAIT:
  - IF/ID forced to NOP with valid 0 every cycle; exc_busy = 1.
  - stall, if_flush, pc_src and exception are all ignored; nested exceptions are dropped and epc is not overwritten.
  - counter != 0: counter decrements, pc held.
  - counter == 0: pc <= EXC_VECTOR, state <= RUN.
  - The first valid fetch at EXC_VECTOR lands in IF/ID on the cycle after returning to RUN.
- Latency: one cycle from PC to IF/ID. The branch redirect takes effect on the next fetch. Exception to first vector fetch = EXC_WAIT_CYCLES+1 edges.
- First edge after reset release fetches PC_RESET; if_id_valid goes high after that edge unless stall, flush or exception is asserted.

Test Plan:
1. Reset release; imem returns 32'h2001_0005 at address 0, 32'h2002_0007 at address 4; no control inputs. -> Edge 1: if_id_instr = 32'h2001_0005, pc4 = 4, valid 1, imem_addr = 4. Edge 2: if_id_instr = 32'h2002_0007, pc4 = 8.
2. At pc = 8, stall held for 3 cycles. -> imem_addr stays 8 and IF/ID unchanged for 3 edges; fetch resumes at 8 on the 4th edge.
3. At pc = 16, pc_src=1, if_flush=1, branch_target = 32'h0000_0043. -> IF/ID becomes NOP (valid 0, pc4 = 20); next imem_addr = 32'h0000_0040.
4. At pc = 12, exception pulse with exc_pc = 32'h0000_0004 and stall=1 in the same cycle. -> epc = 4, exc_busy high for exactly 2 cycles with IF/ID NOP, then imem_addr = 32'h0000_0180; next edge if_id_pc4 = 32'h0000_0184, valid 1.
5. Second exception pulse (exc_pc = 32'h0000_0008) while exc_busy. -> Ignored: epc stays 4, drain length unchanged.
6. Reset asserted asynchronously mid-EXC_WAIT, plus a separate wrap check. -> Immediately: pc = 0, exc_busy = 0, valid 0. Wrap check: pc = 32'hFFFF_FFFC with no stall gives if_id_pc4 = 0 and imem_addr = 0.
